// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 field widths, tag constants and tagged-entry type
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int DATA_W = 1 + EXP_W + MAN_W;

  localparam logic [DATA_W-2:0] FP16_SAT_MAG = 15'h7fff;
  localparam logic [DATA_W-1:0] FP16_ZERO    = 16'h0000;

  typedef struct packed {
    logic              sat;
    logic              zero;
    logic [DATA_W-1:0] data;
  } fp16_tag_t;

endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational saturated / +0 tagging of an FP16 product
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic              sat,
  output logic              zero
);

  // Sign is ignored for saturation; -0 is deliberately not tagged as zero.
  assign sat  = (data[DATA_W-2:0] == FP16_SAT_MAG);
  assign zero = (data == FP16_ZERO);

endmodule

// File: rtl/fp16_result_fifo.sv
// rtl/fp16_result_fifo.sv - tagged FWFT result FIFO behind the FP16 multiplier
module fp16_result_fifo
  import fp16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [15:0]             in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic                    out_sat,
  output logic                    out_zero,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        sat_cnt,
  input  logic                    clr_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  fp16_tag_t        mem [DEPTH];
  fp16_tag_t        in_tag;
  fp16_tag_t        head_q;
  fp16_tag_t        head_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [LVL_W-1:0] level_next;
  logic             in_sat;
  logic             in_zero;
  logic             push;
  logic             pop;
  logic             drop;

  fp16_classify u_classify (
    .data (in_data),
    .sat  (in_sat),
    .zero (in_zero)
  );

  assign in_tag = {in_sat, in_zero, in_data};

  assign pop  = !empty && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // The head register is loaded with the entry that will be at the head after
  // this edge; a write into that very slot has to be forwarded from in_tag.
  always_comb begin
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_next = level;
    head_next  = head_q;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
    if (level_next != '0) begin
      if (push && (rd_next == wr_ptr)) head_next = in_tag;
      else                             head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      level  <= level_next;
      full   <= (level_next == FULL_LVL);
      empty  <= (level_next == '0);
      head_q <= head_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      sat_cnt  <= '0;
    end else if (clr_cnt) begin
      drop_cnt <= '0;
      sat_cnt  <= '0;
    end else begin
      if (drop && (drop_cnt != '1))            drop_cnt <= drop_cnt + 1'b1;
      if (push && in_sat && (sat_cnt != '1))   sat_cnt  <= sat_cnt + 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = head_q.data;
  assign out_sat   = head_q.sat;
  assign out_zero  = head_q.zero;

endmodule

// File: tb/tb_fp16_result_fifo.sv
// tb/tb_fp16_result_fifo.sv - scoreboard bench for fp16_result_fifo
module tb_fp16_result_fifo;
  import fp16_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_sat;
  logic             out_zero;
  logic             full;
  logic             empty;
  logic [3:0]       level;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] sat_cnt;
  logic             clr_cnt;

  int        checks = 0;
  int        errors = 0;
  int        exp_drop = 0;
  int        exp_sat = 0;
  fp16_tag_t exp_q[$];

  fp16_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_zero  (out_zero),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .sat_cnt   (sat_cnt),
    .clr_cnt   (clr_cnt)
  );

  always #5 clk = ~clk;

  function automatic fp16_tag_t tag_of(input logic [15:0] d);
    fp16_tag_t t;
    t.sat  = (d[14:0] == 15'h7fff);
    t.zero = (d == 16'h0000);
    t.data = d;
    return t;
  endfunction

  // One clock: drive inputs, capture the head seen before the edge, update the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic r,
                       output logic popped, output fp16_tag_t head, output logic accepted);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    popped    = (exp_q.size() > 0) && r;
    head      = {out_sat, out_zero, out_data};
    accepted  = v && ((exp_q.size() < DEPTH) || popped);
    @(posedge clk);
    #1;
    if (accepted) begin
      exp_q.push_back(tag_of(d));
      if (tag_of(d).sat && !clr_cnt && exp_sat < 65535) exp_sat++;
    end else if (v && !clr_cnt && exp_drop < 65535) begin
      exp_drop++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b empty=%b full=%b level=%0d exp 0 1 0 0", out_valid, empty, full, level);
    end
    checks++;
    if ({out_sat, out_zero, out_data} !== 18'h0 || drop_cnt !== '0 || sat_cnt !== '0) begin
      errors++;
      $display("FAIL reset_data got out=%h drop=%0d sat=%0d exp 0 0 0", {out_sat, out_zero, out_data}, drop_cnt, sat_cnt);
    end
  endtask

  task automatic test_single;
    logic p, a;
    fp16_tag_t h, e;
    cycle(1'b1, 16'h3C00, 1'b0, p, h, a);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3C00 || out_sat !== 1'b0 || out_zero !== 1'b0 || level !== 4'd1) begin
      errors++;
      $display("FAIL single got valid=%b data=%h sat=%b zero=%b level=%0d exp 1 3c00 0 0 1", out_valid, out_data, out_sat, out_zero, level);
    end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      cycle(1'b0, 16'h0, 1'b1, p, h, a);
      if (p) begin
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL single_drain got %h exp %h", h, e); end
      end
    end
  endtask

  task automatic test_tags;
    logic p, a;
    fp16_tag_t h, e;
    cycle(1'b1, 16'hFFFF, 1'b0, p, h, a);
    cycle(1'b1, 16'h0000, 1'b0, p, h, a);
    cycle(1'b1, 16'h4000, 1'b0, p, h, a);
    checks++;
    if (out_sat !== 1'b1 || out_zero !== 1'b0 || sat_cnt !== 16'(exp_sat)) begin
      errors++;
      $display("FAIL tags_head got sat=%b zero=%b sat_cnt=%0d exp 1 0 %0d", out_sat, out_zero, sat_cnt, exp_sat);
    end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      cycle(1'b0, 16'h0, 1'b1, p, h, a);
      if (p) begin
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL tags_drain got %h exp %h", h, e); end
      end
    end
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tags_empty got empty=%b valid=%b exp 1 0", empty, out_valid);
    end
  endtask

  task automatic test_overflow;
    logic p, a;
    fp16_tag_t h, e;
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 16'(16'h1000 + i), 1'b0, p, h, a);
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || drop_cnt !== 16'(exp_drop) || exp_drop != 3) begin
      errors++;
      $display("FAIL overflow got full=%b level=%0d drop=%0d exp 1 8 3", full, level, drop_cnt);
    end
    checks++;
    if (out_data !== 16'h1000) begin errors++; $display("FAIL overflow_head got %h exp 1000", out_data); end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      cycle(1'b0, 16'h0, 1'b1, p, h, a);
      if (p) begin
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL overflow_drain got %h exp %h", h, e); end
      end
    end
  endtask

  task automatic test_full_pushpop;
    logic p, a;
    fp16_tag_t h, e;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h1100 + i), 1'b0, p, h, a);
    cycle(1'b1, 16'hABCD, 1'b1, p, h, a);
    if (p) begin
      e = exp_q.pop_front();
      checks++;
      if (h !== e) begin errors++; $display("FAIL fullpp_pop got %h exp %h", h, e); end
    end
    checks++;
    if (level !== 4'd8 || full !== 1'b1 || drop_cnt !== 16'(exp_drop) || out_data !== 16'h1101) begin
      errors++;
      $display("FAIL fullpp_state got level=%0d full=%b drop=%0d head=%h exp 8 1 %0d 1101", level, full, drop_cnt, out_data, exp_drop);
    end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      cycle(1'b0, 16'h0, 1'b1, p, h, a);
      if (p) begin
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL fullpp_drain got %h exp %h", h, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic p, a;
    logic r;
    int sent, got;
    fp16_tag_t h, e;
    sent = 0; got = 0; r = 1'b0;
    for (int c = 0; c < 200 && (sent < 20 || exp_q.size() > 0); c++) begin
      r = !r;
      cycle(sent < 20, 16'(16'h2000 + sent), r, p, h, a);
      if (a) sent++;
      if (p) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if (h !== e) begin errors++; $display("FAIL wrap_order got %h exp %h", h, e); end
      end
      checks++;
      if (level > 4'd8 || out_valid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL wrap_level got level=%0d valid=%b exp <=8 %b", level, out_valid, exp_q.size() > 0);
      end
    end
    checks++;
    if (got != 20) begin errors++; $display("FAIL wrap_count got %0d exp 20", got); end
  endtask

  task automatic test_clr_and_rst;
    logic p, a;
    fp16_tag_t h, e;
    clr_cnt = 1'b1;
    cycle(1'b0, 16'h0, 1'b0, p, h, a);
    clr_cnt = 1'b0;
    exp_sat = 0; exp_drop = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h7FFF, 1'b0, p, h, a);
    checks++;
    if (sat_cnt !== 16'd5) begin errors++; $display("FAIL clr_pre got sat_cnt=%0d exp 5", sat_cnt); end
    clr_cnt = 1'b1;
    cycle(1'b1, 16'hFFFF, 1'b0, p, h, a);
    clr_cnt = 1'b0;
    exp_sat = 0; exp_drop = 0;
    checks++;
    if (sat_cnt !== 16'd0 || drop_cnt !== 16'd0 || level !== 4'd6) begin
      errors++;
      $display("FAIL clr_post got sat=%0d drop=%0d level=%0d exp 0 0 6", sat_cnt, drop_cnt, level);
    end
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      cycle(1'b0, 16'h0, 1'b1, p, h, a);
      if (p) begin
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL clr_drain got %h exp %h", h, e); end
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0, p, h, a);
    checks++;
    if (level !== 4'd4) begin errors++; $display("FAIL rst_pre got level=%0d exp 4", level); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || level !== 4'd0 || full !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL rst_async got empty=%b valid=%b level=%0d full=%b data=%h exp 1 0 0 0 0", empty, out_valid, level, full, out_data);
    end
    exp_q.delete();
    exp_sat = 0; exp_drop = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 16'h5555, 1'b0, p, h, a);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5555 || level !== 4'd1) begin
      errors++;
      $display("FAIL rst_after got valid=%b data=%h level=%0d exp 1 5555 1", out_valid, out_data, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tags();
    test_overflow();
    test_full_pushpop();
    test_back_to_back();
    test_clr_and_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
